pd_loop_filter: RTL and testbench
=================================

PD_LOOP_FILTER -- requirements
Module: pd_loop_filter

Interface
REQ-001 SHALL provide parameter PHASE_W, default 6, width of the phase code driving the phase interpolator.
REQ-002 SHALL provide parameter WIN_LOG2, default 3, log2 of the vote window length in CLK cycles (window = 8).
REQ-003 SHALL provide parameter THRESH, default 2, minimum |vote sum| that produces a phase decision.
REQ-004 SHALL provide parameter INT_W, default 8, signed integral accumulator width.
REQ-005 SHALL provide parameter INT_SHIFT, default 4, arithmetic right shift applied to the integral accumulator.
REQ-006 SHALL provide parameter LOCK_N, default 4, number of qualifying decisions required to assert LOCK.
REQ-007 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 SHALL have port RSTb, input, 1 bit: reset, asynchronous assert and active-low.
REQ-009 SHALL have port T, input, 1 bit: transition flag from the bang-bang phase detector.
REQ-010 SHALL have port E, input, 1 bit: early flag from the bang-bang phase detector, meaningful only when T=1.
REQ-011 SHALL have port EN, input, 1 bit: loop enable.
REQ-012 SHALL have port PHASE, output, PHASE_W bits: registered phase code.
REQ-013 SHALL have port UP, output, 1 bit; port DN, output, 1 bit: one-cycle decision pulses.
REQ-014 SHALL have port LOCK, output, 1 bit: registered lock indicator.
REQ-015 SHALL have ports VDD and VSS, inout, 1 bit each: supplies, with no logical function.

Function
REQ-016 Vote each cycle with EN=1 SHALL be: +1 (late) if T=1 and E=0; -1 (early) if T=1 and E=1; 0 if T=0.
REQ-017 Signed vote sum (WIN_LOG2+2 bits) and window counter SHALL accumulate the vote each EN=1 cycle; no overflow is possible.
REQ-018 On the window-closing edge (counter = 2^WIN_LOG2-1, EN=1), decision dir SHALL be computed from the sum including that cycle's vote: +1 if sum>=THRESH, -1 if sum<=-THRESH, else 0; sum and counter clear on the same edge.
REQ-019 On that edge UP SHALL register (dir=+1) and DN SHALL register (dir=-1); both SHALL be 0 on every other cycle and never be high together.
REQ-020 On that edge PHASE SHALL become PHASE + dir + step_i, modulo 2^PHASE_W (circular wrap 63<->0 at default width), where step_i is defined in Configuration.
REQ-021 LOCK counter SHALL saturate-increment at LOCK_N on a decision where dir=0 or dir differs from last nonzero dir (initially 0), and clear to 0 when dir is nonzero and equals last nonzero dir; LOCK SHALL equal (counter==LOCK_N), registered on the decision edge.
REQ-022 While EN=0, votes SHALL be ignored; window counter, vote sum, PHASE, integral and lock state SHALL hold; UP=DN=0; a partial window resumes when EN returns to 1.

Reset
REQ-023 RSTb=0 SHALL asynchronously force PHASE=0, UP=0, DN=0, LOCK=0, vote sum=0, window counter=0, integral=0, lock counter=0, last dir=0, including mid-window.
REQ-024 The first window after reset deassertion SHALL start on the first EN=1 rising CLK edge.

Configuration
REQ-025 With PD_LF_INTEGRAL_EN defined: integral SHALL become sat(integral+dir) within signed INT_W bounds on each decision edge, and step_i SHALL equal the pre-update integral arithmetically shifted right by INT_SHIFT, truncated to PHASE_W bits.
REQ-026 With PD_LF_INTEGRAL_EN undefined: no integral register SHALL exist and step_i SHALL be 0 (proportional-only loop).

Verification
REQ-027 Reset, EN=1, 8 cycles T=1/E=0 -> UP high one cycle after the 8th edge, PHASE=1, DN=0.
REQ-028 Sum within dead zone: 8 cycles votes totalling +1 -> no UP/DN, PHASE unchanged.
REQ-029 Macro undefined: 64 late windows from reset -> PHASE steps 1..63 then wraps to 0.
REQ-030 Alternating late/early windows x4 -> LOCK=1 after the 4th decision; then two consecutive late windows -> LOCK=0 after the second.
REQ-031 Macro defined: 17 consecutive late windows -> PHASE=16 after window 16, PHASE=18 after window 17 (step 2).
REQ-032 EN=0 for 5 cycles mid-window, then RSTb pulsed mid-window -> state holds during EN=0; all outputs/state 0 immediately on RSTb low.

Source files
------------

// File: rtl/pd_loop_filter.sv
// Bang-bang CDR loop filter: windowed vote, dead-zone decision, phase code and lock; PD_LF_INTEGRAL_EN adds an integral path.
// Latency: UP/DN/PHASE/LOCK update one edge after the window-closing edge's inputs are sampled.
// Backpressure: none; EN=0 freezes every state bit and masks votes.
module pd_loop_filter #(
    parameter int PHASE_W   = 6,
    parameter int WIN_LOG2  = 3,
    parameter int THRESH    = 2,
    parameter int INT_W     = 8,
    parameter int INT_SHIFT = 4,
    parameter int LOCK_N    = 4
) (
    input  logic               CLK,
    input  logic               RSTb,
    input  logic               T,
    input  logic               E,
    input  logic               EN,
    output logic [PHASE_W-1:0] PHASE,
    output logic               UP,
    output logic               DN,
    output logic               LOCK,
    inout  wire logic          VDD,
    inout  wire logic          VSS
);

    localparam int SUM_W = WIN_LOG2 + 2;
    localparam int LCW   = $clog2(LOCK_N + 1);
    localparam logic signed [SUM_W-1:0] THR_P    = SUM_W'(THRESH);
    localparam logic signed [SUM_W-1:0] THR_N    = SUM_W'(-THRESH);
    localparam logic [LCW-1:0]          LOCK_MAX = LCW'(LOCK_N);
    localparam logic signed [1:0]       DIR_UP   = 2'sb01;
    localparam logic signed [1:0]       DIR_DN   = 2'sb11;
    localparam logic signed [1:0]       DIR_NONE = 2'sb00;

    // Supplies carry no logic; the XOR only keeps them referenced.
    wire unused_supply;
    assign unused_supply = VDD ^ VSS;

    logic [WIN_LOG2-1:0]     cnt_q, cnt_d;
    logic signed [SUM_W-1:0] sum_q, sum_d;
    logic signed [SUM_W-1:0] sum_nxt;
    logic signed [SUM_W-1:0] vote;
    logic                    win_close;
    logic signed [1:0]       dir;
    logic signed [1:0]       last_dir_q, last_dir_d;
    logic [PHASE_W-1:0]      phase_q, phase_d;
    logic [PHASE_W-1:0]      step_i;
    logic                    up_q, up_d;
    logic                    dn_q, dn_d;
    logic                    lock_q, lock_d;
    logic [LCW-1:0]          lock_cnt_q, lock_cnt_d;

    always_comb begin
        vote = '0;
        if (T) begin
            vote = E ? {SUM_W{1'b1}} : SUM_W'(1);
        end
        sum_nxt   = sum_q + vote;
        win_close = EN && (cnt_q == {WIN_LOG2{1'b1}});
        // Decision uses the sum including the closing cycle's vote.
        if (sum_nxt >= THR_P) begin
            dir = DIR_UP;
        end else if (sum_nxt <= THR_N) begin
            dir = DIR_DN;
        end else begin
            dir = DIR_NONE;
        end
    end

`ifdef PD_LF_INTEGRAL_EN
    localparam logic signed [INT_W:0] INT_MAX = (INT_W+1)'((1 << (INT_W - 1)) - 1);
    localparam logic signed [INT_W:0] INT_MIN = (INT_W+1)'(-(1 << (INT_W - 1)));

    logic signed [INT_W-1:0] integ_q, integ_d;
    logic signed [INT_W-1:0] integ_shr;
    logic signed [INT_W:0]   integ_sum;

    always_comb begin
        integ_shr = integ_q >>> INT_SHIFT;
        // Sign-extending/truncating cast keeps negative steps correct mod 2^PHASE_W.
        step_i    = PHASE_W'(integ_shr);
        integ_sum = (INT_W+1)'(integ_q) + (INT_W+1)'(dir);
        integ_d   = integ_q;
        if (win_close) begin
            if (integ_sum > INT_MAX) begin
                integ_d = INT_MAX[INT_W-1:0];
            end else if (integ_sum < INT_MIN) begin
                integ_d = INT_MIN[INT_W-1:0];
            end else begin
                integ_d = integ_sum[INT_W-1:0];
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            integ_q <= '0;
        end else begin
            integ_q <= integ_d;
        end
    end
`else
    always_comb begin
        step_i = '0;
    end
`endif

    always_comb begin
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        phase_d    = phase_q;
        up_d       = 1'b0;
        dn_d       = 1'b0;
        lock_cnt_d = lock_cnt_q;
        last_dir_d = last_dir_q;
        lock_d     = lock_q;
        if (EN) begin
            cnt_d = cnt_q + WIN_LOG2'(1);
            sum_d = sum_nxt;
        end
        if (win_close) begin
            sum_d   = '0;
            up_d    = (dir == DIR_UP);
            dn_d    = (dir == DIR_DN);
            phase_d = phase_q + PHASE_W'(dir) + step_i;
            // Repeating the same direction means the loop is still slewing, not locked.
            if ((dir != DIR_NONE) && (dir == last_dir_q)) begin
                lock_cnt_d = '0;
            end else if (lock_cnt_q != LOCK_MAX) begin
                lock_cnt_d = lock_cnt_q + LCW'(1);
            end
            if (dir != DIR_NONE) begin
                last_dir_d = dir;
            end
            lock_d = (lock_cnt_d == LOCK_MAX);
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            cnt_q      <= '0;
            sum_q      <= '0;
            phase_q    <= '0;
            up_q       <= 1'b0;
            dn_q       <= 1'b0;
            lock_q     <= 1'b0;
            lock_cnt_q <= '0;
            last_dir_q <= DIR_NONE;
        end else begin
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            phase_q    <= phase_d;
            up_q       <= up_d;
            dn_q       <= dn_d;
            lock_q     <= lock_d;
            lock_cnt_q <= lock_cnt_d;
            last_dir_q <= last_dir_d;
        end
    end

    assign PHASE = phase_q;
    assign UP    = up_q;
    assign DN    = dn_q;
    assign LOCK  = lock_q;

endmodule

// File: tb/tb_pd_loop_filter.sv
// Self-checking bench for pd_loop_filter: vector table, directed corner sequences, randomized run against a window-level model.
module tb_pd_loop_filter;

    localparam int PW  = 6;
    localparam int WIN = 8;
    localparam int TH  = 2;
    localparam int IS  = 4;
    localparam int LN  = 4;

    logic          CLK  = 1'b0;
    logic          RSTb = 1'b0;
    logic          T    = 1'b0;
    logic          E    = 1'b0;
    logic          EN   = 1'b0;
    logic [PW-1:0] PHASE;
    logic          UP, DN, LOCK;
    wire           VDD;
    wire           VSS;
    assign VDD = 1'b1;
    assign VSS = 1'b0;

    pd_loop_filter dut (
        .CLK(CLK), .RSTb(RSTb), .T(T), .E(E), .EN(EN),
        .PHASE(PHASE), .UP(UP), .DN(DN), .LOCK(LOCK),
        .VDD(VDD), .VSS(VSS)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: votes collected per window, decisions computed from the whole window.
    int votes[$];
    int m_phase, m_up, m_dn, m_lock, m_lcnt, m_last, m_integ;

    typedef struct {
        bit t, e, en;
        int up, dn, phase, lock;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        votes.delete();
        m_phase = 0; m_up = 0; m_dn = 0; m_lock = 0;
        m_lcnt = 0; m_last = 0; m_integ = 0;
    endfunction

    function automatic void model_step(input bit t, input bit e, input bit en);
        int s, dir, step;
        m_up = 0;
        m_dn = 0;
        if (!en) return;
        votes.push_back(t ? (e ? -1 : 1) : 0);
        if (votes.size() < WIN) return;
        s = 0;
        foreach (votes[i]) s += votes[i];
        votes.delete();
        dir = (s >= TH) ? 1 : ((s <= -TH) ? -1 : 0);
        m_up = (dir == 1);
        m_dn = (dir == -1);
        step = 0;
`ifdef PD_LF_INTEGRAL_EN
        step = m_integ >>> IS;
        m_integ = m_integ + dir;
        if (m_integ > 127) m_integ = 127;
        if (m_integ < -128) m_integ = -128;
`endif
        m_phase = (((m_phase + dir + step) % 64) + 64) % 64;
        if (dir != 0 && dir == m_last) m_lcnt = 0;
        else if (m_lcnt < LN) m_lcnt++;
        if (dir != 0) m_last = dir;
        m_lock = (m_lcnt == LN);
    endfunction

    task automatic compare_model();
        check("phase", int'(PHASE), m_phase);
        check("up", int'(UP), m_up);
        check("dn", int'(DN), m_dn);
        check("lock", int'(LOCK), m_lock);
        check("up_dn_exclusive", int'(UP & DN), 0);
    endtask

    task automatic cyc(input bit t, input bit e, input bit en);
        T = t; E = e; EN = en;
        @(posedge CLK);
        model_step(t, e, en);
        #1;
        compare_model();
    endtask

    // kind: +1 late window, -1 early window, 0 no transitions
    task automatic win(input int kind);
        repeat (WIN) cyc(kind != 0, kind < 0, 1'b1);
    endtask

    task automatic do_reset();
        RSTb = 1'b0; T = 1'b0; E = 1'b0; EN = 1'b0;
        #1;
        model_reset();
        check("rst_phase", int'(PHASE), 0);
        check("rst_up", int'(UP), 0);
        check("rst_dn", int'(DN), 0);
        check("rst_lock", int'(LOCK), 0);
        @(posedge CLK);
        #1;
        RSTb = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int lock_exp[6];
        int kinds[6];
        int bias;

        // ---- table: 8 late cycles from reset, then EN=0 hold, then a fresh early vote
        for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, 1'b0, 1'b1, (i == 7) ? 1 : 0, 0, (i == 7) ? 1 : 0, 0};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 0, 0, 1, 0};
        tbl[9] = '{1'b1, 1'b1, 1'b1, 0, 0, 1, 0};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            T = tbl[i].t; E = tbl[i].e; EN = tbl[i].en;
            @(posedge CLK);
            model_step(tbl[i].t, tbl[i].e, tbl[i].en);
            #1;
            check($sformatf("tbl%0d_up", i), int'(UP), tbl[i].up);
            check($sformatf("tbl%0d_dn", i), int'(DN), tbl[i].dn);
            check($sformatf("tbl%0d_phase", i), int'(PHASE), tbl[i].phase);
            check($sformatf("tbl%0d_lock", i), int'(LOCK), tbl[i].lock);
        end

        // ---- dead zone: votes total +1
        do_reset();
        repeat (4) cyc(1'b1, 1'b0, 1'b1);
        repeat (3) cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        check("deadzone_up", int'(UP), 0);
        check("deadzone_dn", int'(DN), 0);
        check("deadzone_phase", int'(PHASE), 0);

        // ---- threshold boundary: sum exactly -2 gives DN
        do_reset();
        repeat (2) cyc(1'b1, 1'b1, 1'b1);
        repeat (6) cyc(1'b0, 1'b0, 1'b1);
        check("thresh_dn", int'(DN), 1);
        check("thresh_phase", int'(PHASE), 63);

`ifndef PD_LF_INTEGRAL_EN
        // ---- 64 late windows: phase 1..63 then wraps to 0
        do_reset();
        for (int w = 1; w <= 64; w++) begin
            win(1);
            check($sformatf("wrap_w%0d", w), int'(PHASE), w % 64);
        end
`else
        // ---- integral path: step of 1 appears on window 17
        do_reset();
        for (int w = 1; w <= 17; w++) begin
            win(1);
            if (w == 16) check("integ_w16", int'(PHASE), 16);
            if (w == 17) check("integ_w17", int'(PHASE), 18);
        end
`endif

        // ---- lock: alternate x4, then two late windows
        do_reset();
        kinds    = '{1, -1, 1, -1, 1, 1};
        lock_exp = '{0, 0, 0, 1, 1, 0};
        for (int k = 0; k < 6; k++) begin
            win(kinds[k]);
            check($sformatf("lock_dec%0d", k + 1), int'(LOCK), lock_exp[k]);
        end

        // ---- EN=0 hold mid-window, resume, then async reset mid-window
        do_reset();
        repeat (3) cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            check("hold_phase", int'(PHASE), 0);
            check("hold_dn", int'(DN), 0);
        end
        repeat (4) cyc(1'b1, 1'b0, 1'b1);
        check("resume_no_early_up", int'(UP), 0);
        cyc(1'b1, 1'b0, 1'b1);
        check("resume_up", int'(UP), 1);
        check("resume_phase", int'(PHASE), 1);
        repeat (3) cyc(1'b1, 1'b0, 1'b1);
        #2;
        RSTb = 1'b0;
        #1;
        check("async_phase", int'(PHASE), 0);
        check("async_up", int'(UP), 0);
        check("async_dn", int'(DN), 0);
        check("async_lock", int'(LOCK), 0);
        model_reset();
        @(posedge CLK);
        #1;
        RSTb = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 1'b1);
            check($sformatf("post_rst_up%0d", i), int'(UP), (i == 7) ? 1 : 0);
        end

        // ---- randomized run against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            case ((i / 300) % 4)
                0: bias = 15;
                1: bias = 50;
                2: bias = 85;
                default: bias = 45;
            endcase
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 99) < bias, $urandom_range(0, 7) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
